// File: rtl/prescaled_updown_counter.sv
// Programmable prescaler driving a bounded up/down counter.
// Load, wrap/saturate at bounds, terminal-count pulse.
module prescaled_updown_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int DIV_WIDTH = 32,
    parameter int unsigned DEFAULT_DIV = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 up_not_down,
    input  logic                 sat_mode,
    input  logic [CNT_WIDTH-1:0] max_val,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 div_wr,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tc,
    output logic [DIV_WIDTH-1:0] freq_div_out
);

    logic [DIV_WIDTH-1:0] period_reg;
    logic [DIV_WIDTH-1:0] presc;
    logic [DIV_WIDTH-1:0] presc_last;
    logic [CNT_WIDTH-1:0] load_clamp;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 tc_nxt;

    // Last prescaler value of a period; periods of 0 and 1 tick every cycle
    always_comb begin
        presc_last = '0;
        if (period_reg > DIV_WIDTH'(1)) begin
            presc_last = period_reg - DIV_WIDTH'(1);
        end
    end

    // Loaded value is clamped to the upper bound
    always_comb begin
        load_clamp = load_val;
        if (load_val > max_val) begin
            load_clamp = max_val;
        end
    end

    // Next count for one step, bounds checked before stepping
    always_comb begin
        cnt_nxt = count;
        tc_nxt  = 1'b0;
        if (up_not_down) begin
            if (count < max_val) begin
                cnt_nxt = count + CNT_WIDTH'(1);
            end else if (sat_mode) begin
                cnt_nxt = max_val;
            end else begin
                cnt_nxt = '0;
            end
            tc_nxt = (cnt_nxt == max_val);
        end else begin
            if (count != '0) begin
                cnt_nxt = count - CNT_WIDTH'(1);
            end else if (sat_mode) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = max_val;
            end
            tc_nxt = (cnt_nxt == '0);
        end
    end

    // Period register, prescaler and registered tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_reg <= DIV_WIDTH'(DEFAULT_DIV);
            presc      <= '0;
            tick       <= 1'b0;
        end else if (div_wr) begin
            period_reg <= div_val;
            presc      <= '0;
            tick       <= 1'b0;
        end else if (load) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (presc >= presc_last) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + DIV_WIDTH'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Count update: load wins over a pending tick, tc only on steps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamp;
            tc    <= 1'b0;
        end else if (tick) begin
            count <= cnt_nxt;
            tc    <= tc_nxt;
        end else begin
            tc <= 1'b0;
        end
    end

    assign freq_div_out = presc;

endmodule

// File: doc/prescaled_updown_counter.md
Name: prescaled_updown_counter

Overview:
Parametrised successor to the fixed 1 s up/down counter. It combines a runtime-programmable prescaler and a bounded up/down counter. The counter has load, enable, wrap/saturate mode and terminal-count flag. It sits behind the board clock (100 MHz) and drives display/timebase logic with a count that advances once per prescaler tick.

Parameters:
CNT_WIDTH, 32, width of count, load_val, max_val
DIV_WIDTH, 32, width of prescaler and div_val
DEFAULT_DIV, 100_000_000, prescaler period after reset (1 s at 100 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  1 = prescaler runs; 0 = prescaler and count hold
load  input  1  synchronous load of load_val, priority over tick
load_val  input  CNT_WIDTH  value loaded into count
up_not_down  input  1  1 = count up, 0 = count down
sat_mode  input  1  0 = wrap at bounds, 1 = saturate at bounds
max_val  input  CNT_WIDTH  upper bound of count (lower bound fixed 0)
div_val  input  DIV_WIDTH  prescaler period in clk cycles; 0 and 1 both mean every cycle
div_wr  input  1  1-cycle strobe: capture div_val into internal period register
tick  output  1  1-cycle pulse at end of each prescaler period
count  output  CNT_WIDTH  counter value
tc  output  1  1-cycle pulse when count reaches boundary on a tick
freq_div_out  output  DIV_WIDTH  current prescaler value (debug)

Behaviour:
- Reset (rst=0, async): period_reg=DEFAULT_DIV, prescaler=0, count=0, tick=0, tc=0.
- Prescaler: when en=1, it counts 0..P-1, where P=max(period_reg,1).
  - At prescaler==P-1: prescaler→0 and tick=1 in the following cycle (registered; 1-cycle latency).
  - en=0 freezes the prescaler and tick=0.
- div_wr=1: period_reg←div_val and prescaler→0 in the same edge; no tick that cycle.
- Count step, on registered tick=1 only:
  - up, count<max_val: count+1.
  - up, count>=max_val: wrap→0 (sat_mode=0) or hold at max_val (sat_mode=1).
  - down, count>0: count-1.
  - down, count==0: wrap→max_val (sat_mode=0) or hold 0 (sat_mode=1).
- Load: load=1 sets count←min(load_val,max_val) and prescaler→0, independent of en.
  - A tick in the same cycle is ignored (load wins).
  - Holding load=1 keeps the prescaler at 0, so no ticks.
- tc: 1 for exactly one cycle, coincident with the count update, when the step produces count==max_val (up) or count==0 (down).
  - tc is also asserted on a saturated hold at the bound.
  - tc is never asserted on load.
- max_val lowered below current count:
  - Next up tick applies the wrap/saturate rule.
  - Next down tick decrements normally.
- max_val=0: count stays 0; tc pulses on every tick.
- up_not_down change takes effect at the next tick; no glitch or skipped step.
- rst asserted mid-period: immediate return to reset values; period_reg returns to DEFAULT_DIV.
- All arithmetic unsigned and width-exact; no overflow beyond CNT_WIDTH (bounds are checked before step).

Test Plan:
1. rst=0 for 5 cycles, release, en=1, div_wr with div_val=4 → tick every 4th cycle; count 0,1,2,3 after 4 ticks; freq_div_out cycles 0..3.
2. max_val=5, up, sat_mode=0, div 2 → count 0..5 then 0; tc=1 exactly on the 4→5 step.
3. Same with sat_mode=1 → count holds 5, tc=1 on each subsequent tick; then switch up_not_down=0 → 4,3,...,0 with tc at 0, then holds 0.
4. load=1 with load_val=9, max_val=7 → count=7 next cycle, prescaler=0, no tc. Load asserted on a tick cycle → loaded value, no step.
5. div_val=0 and div_val=1 → tick every cycle; en=0 mid-period → freq_div_out frozen, no tick. Resume continues from the frozen value.
6. Async rst pulse between clock edges mid-count (count=3, prescaler=2) → all outputs 0 immediately. After release, period=DEFAULT_DIV (override DEFAULT_DIV=10 for simulation).
